// File: rtl/control_sequencer.sv
// control_sequencer
//   Hardwired Moore control unit sitting directly upstream of the CPU
//   datapath. It walks the fetch T-states (F0..F2) and then the execute
//   T-states (T3..T7) chosen by the opcode in IR[31:27]. All outputs are a
//   combinational decode of the registered state plus the current opcode.
//
// Optional feature macro: MEM_WAIT_EN
//   When defined, memory states (F1, ld T6, st T7) stall until MemReady is
//   sampled high. A stall of WAIT_LIMIT cycles raises Illegal for one cycle
//   and parks the machine in HALT. When undefined, MemReady is ignored and
//   every memory state lasts exactly one cycle.
//
// Ports
//   clock                 rising-edge clock
//   clear                 synchronous active-high reset (next state RST)
//   IR[31:0]              current instruction, opcode in IR[31:27]
//   MemReady              memory access complete (MEM_WAIT_EN only)
//   Gra/Grb/Grc           register-field selects (IR[26:23]/[22:19]/[18:15])
//   Rin/Rout              load / drive selected general register
//   Cout                  drive sign-extended IR[18:0] onto the bus
//   PCout/PCin/IncPC      program-counter controls
//   MARin/MDRin/MDRout    memory-interface register controls
//   MDRread               1 selects memory data into MDR
//   IRin/Yin/Zin          datapath register loads
//   Zlowout/Zhighout      drive Z low / high half onto the bus
//   HIin/LOin             load HI / LO result registers
//   ALUselect[3:0]        ALU operation code
//   MemRead/MemWrite      memory strobes
//   Run                   1 while executing, 0 once halted
//   Illegal               one-cycle pulse on bad opcode or memory timeout
module control_sequencer #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        MemReady,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        Cout,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        MDRread,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HIin,
  output logic        LOin,
  output logic [3:0]  ALUselect,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        Run,
  output logic        Illegal
);

  typedef enum logic [3:0] {
    S_RST, S_F0, S_F1, S_F2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT, S_FAULT
  } state_e;

  localparam logic [3:0] ALU_ADD = 4'b0000;

  state_e     state_q, state_d;
  logic [4:0] opcode;
  logic       is_rfmt, is_addi, is_muldiv, is_ld, is_st, is_nop, is_halt;
  logic       mem_go, mem_timeout;

  function automatic logic [3:0] alu_code(input logic [4:0] op);
    case (op)
      5'b00011: alu_code = 4'b0000;
      5'b00100: alu_code = 4'b0001;
      5'b00101: alu_code = 4'b0010;
      5'b00110: alu_code = 4'b0011;
      5'b00111: alu_code = 4'b0100;
      5'b01000: alu_code = 4'b0101;
      5'b01111: alu_code = 4'b0110;
      5'b10000: alu_code = 4'b0111;
      default:  alu_code = 4'b0000;
    endcase
  endfunction

  assign opcode = IR[31:27];

  always_comb begin
    is_rfmt   = 1'b0;
    is_addi   = 1'b0;
    is_muldiv = 1'b0;
    is_ld     = 1'b0;
    is_st     = 1'b0;
    is_nop    = 1'b0;
    is_halt   = 1'b0;
    case (opcode)
      5'b00011, 5'b00100, 5'b00101,
      5'b00110, 5'b00111, 5'b01000: is_rfmt   = 1'b1;
      5'b01100:                     is_addi   = 1'b1;
      5'b01111, 5'b10000:           is_muldiv = 1'b1;
      5'b00000:                     is_ld     = 1'b1;
      5'b00010:                     is_st     = 1'b1;
      5'b11011:                     is_nop    = 1'b1;
      5'b11100:                     is_halt   = 1'b1;
      default: ;
    endcase
  end

`ifdef MEM_WAIT_EN
  localparam int CNT_W = $clog2(WAIT_LIMIT + 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             in_mem_state;
  logic             unused_ir;

  assign in_mem_state = (state_q == S_F1) || (state_q == S_T6 && is_ld) ||
                        (state_q == S_T7 && is_st);
  assign mem_go       = MemReady;
  assign mem_timeout  = (wait_cnt_q == CNT_W'(WAIT_LIMIT - 1));
  // Counts only while parked in a memory state; any transition zeroes it,
  // so each memory state starts from 0 on entry.
  assign wait_cnt_d   = (in_mem_state && state_d == state_q) ? wait_cnt_q + 1'b1 : '0;
  assign unused_ir    = ^IR[26:0];

  always_ff @(posedge clock) begin
    if (clear) wait_cnt_q <= '0;
    else       wait_cnt_q <= wait_cnt_d;
  end
`else
  logic unused_in;

  assign mem_go      = 1'b1;
  assign mem_timeout = 1'b0;
  assign unused_in   = ^{IR[26:0], MemReady} ^ WAIT_LIMIT[0];
`endif

  always_ff @(posedge clock) begin
    if (clear) state_q <= S_RST;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    Gra       = 1'b0; Grb     = 1'b0; Grc      = 1'b0;
    Rin       = 1'b0; Rout    = 1'b0; Cout     = 1'b0;
    PCout     = 1'b0; PCin    = 1'b0; IncPC    = 1'b0;
    MARin     = 1'b0; MDRin   = 1'b0; MDRout   = 1'b0; MDRread = 1'b0;
    IRin      = 1'b0; Yin     = 1'b0; Zin      = 1'b0;
    Zlowout   = 1'b0; Zhighout = 1'b0; HIin    = 1'b0; LOin    = 1'b0;
    ALUselect = 4'b0000;
    MemRead   = 1'b0; MemWrite = 1'b0;
    Run       = 1'b1; Illegal  = 1'b0;

    case (state_q)
      S_RST: state_d = S_F0;
      S_F0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        ALUselect = ALU_ADD;
        state_d = S_F1;
      end
      S_F1: begin
        Zlowout = 1'b1; PCin = 1'b1; MemRead = 1'b1; MDRin = 1'b1; MDRread = 1'b1;
        if (mem_go)           state_d = S_F2;
        else if (mem_timeout) state_d = S_FAULT;
      end
      S_F2: begin
        MDRout = 1'b1; IRin = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        if (is_rfmt || is_addi || is_ld || is_st) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
          state_d = S_T4;
        end else if (is_muldiv) begin
          Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
          state_d = S_T4;
        end else if (is_nop) begin
          state_d = S_F0;
        end else if (is_halt) begin
          state_d = S_HALT;
        end else begin
          // Undefined opcode: flag it and carry on as a nop.
          Illegal = 1'b1;
          state_d = S_F0;
        end
      end
      S_T4: begin
        Zin = 1'b1;
        state_d = S_T5;
        if (is_addi || is_ld || is_st) begin
          Cout = 1'b1; ALUselect = ALU_ADD;
        end else if (is_rfmt) begin
          Grc = 1'b1; Rout = 1'b1; ALUselect = alu_code(opcode);
        end else if (is_muldiv) begin
          Grb = 1'b1; Rout = 1'b1; ALUselect = alu_code(opcode);
        end else begin
          Zin = 1'b0;
          state_d = S_F0;
        end
      end
      S_T5: begin
        state_d = S_F0;
        if (is_rfmt || is_addi) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (is_muldiv) begin
          Zlowout = 1'b1; LOin = 1'b1;
          state_d = S_T6;
        end else if (is_ld || is_st) begin
          Zlowout = 1'b1; MARin = 1'b1;
          state_d = S_T6;
        end
      end
      S_T6: begin
        state_d = S_F0;
        if (is_muldiv) begin
          Zhighout = 1'b1; HIin = 1'b1;
        end else if (is_ld) begin
          MemRead = 1'b1; MDRin = 1'b1; MDRread = 1'b1;
          if (mem_go)           state_d = S_T7;
          else if (mem_timeout) state_d = S_FAULT;
          else                  state_d = S_T6;
        end else if (is_st) begin
          Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
          state_d = S_T7;
        end
      end
      S_T7: begin
        state_d = S_F0;
        if (is_ld) begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (is_st) begin
          MemWrite = 1'b1;
          if (mem_go)           state_d = S_F0;
          else if (mem_timeout) state_d = S_FAULT;
          else                  state_d = S_T7;
        end
      end
      S_HALT: Run = 1'b0;
      S_FAULT: begin
        Illegal = 1'b1;
        state_d = S_HALT;
      end
      default: state_d = S_RST;
    endcase
  end

endmodule
